orb_frame_packer: RTL and testbench
===================================

ORB_FRAME_PACKER -- requirements
Module: orb_frame_packer

Interface
REQ-001 SHALL have parameter DW, default 8, input data byte width.
REQ-002 SHALL have parameter OW, default 12, output word width; OW >= DW+1.
REQ-003 SHALL have parameter WPP, default 16, data slots written per packet.
REQ-004 SHALL have parameter SKIP, default 4, trailing slots per packet that are not written.
REQ-005 SHALL have parameter NPACK, default 64, packets per bank before address wrap.
REQ-006 SHALL have parameter AW, default 11, write address width.
REQ-007 SHALL have parameter ASTEP, default 2, address increment per data slot.
REQ-008 SHALL have parameter WE_DLY, default 30, cycles from capture to WE assertion (1..255).
REQ-009 SHALL have ports: clk in 1 system clock; rst in 1 reset (one clock; reset is asynchronous and active-high).
REQ-010 SHALL have ports: iData in DW byte; strob in 1 async slot strobe; SW in 1 async bank-restart toggle.
REQ-011 SHALL have ports: orbWord out OW; WE out 1 RAM write enable; WrAddr out AW RAM address.
REQ-012 SHALL have ports: swPulse out 1 (SW edge seen); packDone out 1 (packet end); bankWrap out 1 (last packet end); ovf out 1 (sticky short-strobe error).

Function
REQ-013 SHALL synchronise strob and SW through two flops each; sStr, sSW denote stage-2 outputs.
REQ-014 SHALL implement states IDLE, WESET, WAIT.
REQ-015 IDLE, sStr=1: slot counter cntWrd increments; if cntWrd < WPP, latch orbWord, WrAddr, cntAddr+1, go WESET; else go WAIT.
REQ-016 Word format SHALL be {P, iData, zeros(OW-DW-1)}; P=0 unless REQ-028.
REQ-017 WrAddr SHALL be cntAddr*ASTEP + cntPack*WPP*ASTEP, truncated to AW bits.
REQ-018 At slot WPP+SKIP-1: cntWrd<=0, cntAddr<=0, packDone pulses one cycle; cntPack increments, wrapping NPACK-1 -> 0 with bankWrap one-cycle pulse.
REQ-019 WESET: counter cntWE counts from 0; at cntWE=WE_DLY WE<=1; next cycle cntWE<=0, go WAIT.
REQ-020 WAIT: when sStr=0, WE<=0, go IDLE; WE width therefore equals residual strobe time.
REQ-021 If sStr falls while in WESET, ovf SHALL set (sticky until reset); FSM still completes WESET then WAIT normally.
REQ-022 sSW differing from its previous sampled value SHALL clear cntWrd, cntAddr, cntPack, cntWE... except cntWE in WESET, and pulse swPulse one cycle.
REQ-023 SW edge coinciding with IDLE sStr=1: clear wins, strobe ignored in that cycle, FSM stays IDLE and re-evaluates next cycle with counters at 0.
REQ-024 SW edge during WESET/WAIT: in-flight write completes at latched WrAddr; subsequent slot starts at address 0.

Reset
REQ-025 rst=1 SHALL asynchronously force state IDLE, all counters 0, synchronisers 0, previous-SW 0.
REQ-026 During reset orbWord=0, WE=0, WrAddr=0, swPulse=0, packDone=0, bankWrap=0, ovf=0.
REQ-027 Reset asserted mid-write SHALL drop WE immediately; first strobe after release writes address 0.

Configuration
REQ-028 Macro ORB_FRAME_PACKER_PARITY_EN defined: P = odd parity of iData (XOR-reduce inverted).
REQ-029 Macro undefined: P = 0, no parity logic synthesised; all other behaviour identical.

Verification
REQ-030 Defaults, 20 strobes iData=0x00..0x13: writes at 0,2,...,30 with orbWord=iData<<3; no WE for slots 16-19; packDone pulse after 20th.
REQ-031 Strobe high 40 cycles: WE rises exactly WE_DLY+1 cycles after capture cycle, falls 1 cycle after sStr low; ovf=0.
REQ-032 Strobe high 10 cycles: ovf=1 and stays 1; write still occurs.
REQ-033 64 full packets: last write WrAddr=2046, bankWrap pulses once, next packet starts at 0.
REQ-034 SW toggle after 5 slots of packet 3: swPulse pulse, next write at WrAddr=0.
REQ-035 PARITY_EN, iData=0x01: orbWord=0x008; iData=0x03: orbWord=0x818; without macro both MSB=0.

Source files
------------

// File: rtl/orb_frame_packer.sv
// Packs strobed data bytes into RAM words with a delayed write enable and packet/bank addressing.
// Optional odd-parity MSB is enabled by defining ORB_FRAME_PACKER_PARITY_EN.
module orb_frame_packer #(
    parameter int unsigned DW     = 8,
    parameter int unsigned OW     = 12,
    parameter int unsigned WPP    = 16,
    parameter int unsigned SKIP   = 4,
    parameter int unsigned NPACK  = 64,
    parameter int unsigned AW     = 11,
    parameter int unsigned ASTEP  = 2,
    parameter int unsigned WE_DLY = 30
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] iData,
    input  logic          strob,
    input  logic          SW,
    output logic [OW-1:0] orbWord,
    output logic          WE,
    output logic [AW-1:0] WrAddr,
    output logic          swPulse,
    output logic          packDone,
    output logic          bankWrap,
    output logic          ovf
);

    localparam int unsigned CW  = (WPP + SKIP > 1) ? $clog2(WPP + SKIP) : 1;
    localparam int unsigned AAW = $clog2(WPP + 1);
    localparam int unsigned PW  = (NPACK > 1) ? $clog2(NPACK) : 1;

    typedef enum logic [1:0] {IDLE, WESET, WAIT} state_t;

    state_t         state;
    logic           str1, sStr, sw1, sSW, prevSW;
    logic [CW-1:0]  cntWrd;
    logic [AAW-1:0] cntAddr;
    logic [PW-1:0]  cntPack;
    logic [7:0]     cntWE;
    logic           swEdge, par, writeSlot, lastSlot;
    logic [OW-1:0]  word;
    logic [31:0]    addrFull;

`ifdef ORB_FRAME_PACKER_PARITY_EN
    assign par = ~^iData;
`else
    assign par = 1'b0;
`endif

    always_comb begin
        word          = '0;
        word[OW-1]    = par;
        word[OW-2 -: DW] = iData;
    end

    assign swEdge    = sSW != prevSW;
    assign writeSlot = 32'(cntWrd) < WPP;
    assign lastSlot  = cntWrd == CW'(WPP + SKIP - 1);
    assign addrFull  = 32'(cntAddr) * ASTEP + 32'(cntPack) * (WPP * ASTEP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            str1     <= 1'b0;
            sStr     <= 1'b0;
            sw1      <= 1'b0;
            sSW      <= 1'b0;
            prevSW   <= 1'b0;
            cntWrd   <= '0;
            cntAddr  <= '0;
            cntPack  <= '0;
            cntWE    <= '0;
            orbWord  <= '0;
            WE       <= 1'b0;
            WrAddr   <= '0;
            swPulse  <= 1'b0;
            packDone <= 1'b0;
            bankWrap <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            str1     <= strob;
            sStr     <= str1;
            sw1      <= SW;
            sSW      <= sw1;
            prevSW   <= sSW;
            swPulse  <= 1'b0;
            packDone <= 1'b0;
            bankWrap <= 1'b0;

            // Bank restart; an in-flight WESET keeps its delay count so the latched write completes.
            if (swEdge) begin
                swPulse <= 1'b1;
                cntWrd  <= '0;
                cntAddr <= '0;
                cntPack <= '0;
                if (state != WESET)
                    cntWE <= '0;
            end

            case (state)
                IDLE: begin
                    if (sStr && !swEdge) begin
                        if (lastSlot) begin
                            cntWrd   <= '0;
                            cntAddr  <= '0;
                            packDone <= 1'b1;
                            if (cntPack == PW'(NPACK - 1)) begin
                                cntPack  <= '0;
                                bankWrap <= 1'b1;
                            end else begin
                                cntPack <= cntPack + PW'(1);
                            end
                        end else begin
                            cntWrd <= cntWrd + CW'(1);
                        end
                        if (writeSlot) begin
                            orbWord <= word;
                            WrAddr  <= addrFull[AW-1:0];
                            cntWE   <= '0;
                            if (!lastSlot)
                                cntAddr <= cntAddr + AAW'(1);
                            state <= WESET;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WESET: begin
                    if (!sStr)
                        ovf <= 1'b1;
                    if (cntWE == 8'(WE_DLY)) begin
                        WE    <= 1'b1;
                        cntWE <= '0;
                        state <= WAIT;
                    end else begin
                        cntWE <= cntWE + 8'd1;
                    end
                end
                WAIT: begin
                    if (!sStr) begin
                        WE    <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_orb_frame_packer.sv
// Self-checking bench for orb_frame_packer: slot/packet model with a per-cycle write checker.
module tb_orb_frame_packer;
    localparam int unsigned DW = 8, OW = 12, WPP = 16, SKIP = 4, NPACK = 64;
    localparam int unsigned AW = 11, ASTEP = 2, WE_DLY = 30;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] iData = '0;
    logic          strob = 1'b0;
    logic          SW = 1'b0;
    logic [OW-1:0] orbWord;
    logic          WE;
    logic [AW-1:0] WrAddr;
    logic          swPulse, packDone, bankWrap, ovf;

    orb_frame_packer #(.DW(DW), .OW(OW), .WPP(WPP), .SKIP(SKIP), .NPACK(NPACK),
                       .AW(AW), .ASTEP(ASTEP), .WE_DLY(WE_DLY)) dut (
        .clk(clk), .rst(rst), .iData(iData), .strob(strob), .SW(SW),
        .orbWord(orbWord), .WE(WE), .WrAddr(WrAddr), .swPulse(swPulse),
        .packDone(packDone), .bankWrap(bankWrap), .ovf(ovf)
    );

    always #5 clk = ~clk;

    int errors = 0, checks = 0;

    typedef struct { logic [AW-1:0] addr; logic [OW-1:0] word; } wr_t;
    wr_t exp_q[$];
    int  m_slot = 0, m_pack = 0;

    int n_we = 0, n_pd = 0, n_bw = 0, n_sw = 0;
    logic [AW-1:0] last_addr = '0;
    logic [OW-1:0] last_word = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [OW-1:0] model_word(input logic [DW-1:0] d);
        logic [OW-1:0] w;
        w = OW'(d) << (OW - DW - 1);
`ifdef ORB_FRAME_PACKER_PARITY_EN
        w[OW-1] = ~^d;
`endif
        return w;
    endfunction

    // Advances the slot model by one strobe; returns the strobe high time to use.
    task automatic model_slot(input logic [DW-1:0] d, output int hi);
        wr_t e;
        if (m_slot < int'(WPP)) begin
            e.addr = AW'(m_slot * ASTEP + m_pack * WPP * ASTEP);
            e.word = model_word(d);
            exp_q.push_back(e);
            hi = 35;
        end else begin
            hi = 2;
        end
        if (m_slot == int'(WPP + SKIP - 1)) begin
            m_slot = 0;
            m_pack = (m_pack == int'(NPACK - 1)) ? 0 : m_pack + 1;
        end else begin
            m_slot++;
        end
    endtask

    task automatic do_strobe(input logic [DW-1:0] d);
        int hi;
        model_slot(d, hi);
        @(posedge clk); #1;
        iData = d;
        strob = 1'b1;
        repeat (hi) @(posedge clk);
        #1 strob = 1'b0;
        repeat (5) @(posedge clk);
    endtask

    task automatic model_restart();
        m_slot = 0;
        m_pack = 0;
    endtask

    // Per-cycle compare against the model queue, plus pulse bookkeeping.
    initial begin
        wr_t  cur;
        logic we_d;
        we_d = 1'b0;
        cur.addr = '0;
        cur.word = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                check("reset_outputs", 32'({orbWord, WE, WrAddr, swPulse, packDone, bankWrap, ovf}), 32'd0);
            end else begin
                if (WE && !we_d) begin
                    n_we++;
                    last_addr = WrAddr;
                    last_word = orbWord;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_write: got WrAddr=0x%0h expected no write at %0t", WrAddr, $time);
                    end else begin
                        cur = exp_q.pop_front();
                    end
                end
                if (WE) begin
                    check("wr_addr", 32'(WrAddr), 32'(cur.addr));
                    check("wr_word", 32'(orbWord), 32'(cur.word));
                end
                if (packDone) n_pd++;
                if (bankWrap) n_bw++;
                if (swPulse)  n_sw++;
            end
            we_d = WE;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int b_we, b_pd, b_bw, b_sw, hi, k;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("ovf_after_reset", 32'(ovf), 32'd0);

        // 20 strobes 0x00..0x13: 16 writes, packDone only after the 20th
        b_we = n_we; b_pd = n_pd;
        for (int i = 0; i < 20; i++) begin
            do_strobe(DW'(i));
            if (i == 18) check("packdone_early", 32'(n_pd - b_pd), 32'd0);
        end
        check("pkt_writes", 32'(n_we - b_we), 32'd16);
        check("pkt_done", 32'(n_pd - b_pd), 32'd1);
        check("pkt_last_addr", 32'(last_addr), 32'd30);
`ifdef ORB_FRAME_PACKER_PARITY_EN
        check("pkt_last_word", 32'(last_word), 32'h878);
`else
        check("pkt_last_word", 32'(last_word), 32'h078);
`endif

        // WE timing with a 40-cycle strobe
        model_slot(8'hA5, hi);
        @(posedge clk); #1;
        iData = 8'hA5;
        strob = 1'b1;
        for (k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (k == 33) check("we_early", 32'(WE), 32'd0);
            if (k == 34) check("we_rise", 32'(WE), 32'd1);
        end
        strob = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("we_hold", 32'(WE), 32'd1);
        @(posedge clk); #1;
        check("we_fall", 32'(WE), 32'd0);
        check("ovf_long", 32'(ovf), 32'd0);
        check("addr_slot0_pkt1", 32'(last_addr), 32'd32);
`ifdef ORB_FRAME_PACKER_PARITY_EN
        check("word_a5", 32'(last_word), 32'hD28);
`else
        check("word_a5", 32'(last_word), 32'h528);
`endif
        repeat (3) @(posedge clk);

        // Parity literals
        do_strobe(8'h01);
        check("word_01", 32'(last_word), 32'h008);
        do_strobe(8'h03);
`ifdef ORB_FRAME_PACKER_PARITY_EN
        check("word_03", 32'(last_word), 32'h818);
`else
        check("word_03", 32'(last_word), 32'h018);
`endif

        // Short strobe sets sticky ovf, write still happens
        b_we = n_we;
        model_slot(8'h3C, hi);
        @(posedge clk); #1;
        iData = 8'h3C;
        strob = 1'b1;
        repeat (10) @(posedge clk);
        #1 strob = 1'b0;
        repeat (40) @(posedge clk);
        check("ovf_short", 32'(ovf), 32'd1);
        check("short_write", 32'(n_we - b_we), 32'd1);
        do_strobe(8'h44);
        check("ovf_sticky", 32'(ovf), 32'd1);

        // Reset mid-write drops WE at once; first write afterwards lands at 0
        model_slot(8'h11, hi);
        @(posedge clk); #1;
        iData = 8'h11;
        strob = 1'b1;
        k = 0;
        while (!WE && k < 60) begin
            @(negedge clk);
            k++;
        end
        check("we_before_reset", 32'(WE), 32'd1);
        #2 rst = 1'b1;
        #1 check("we_async_drop", 32'(WE), 32'd0);
        strob = 1'b0;
        exp_q.delete();
        model_restart();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("ovf_cleared", 32'(ovf), 32'd0);
        do_strobe(8'h22);
        check("addr_after_reset", 32'(last_addr), 32'd0);

        // Full bank: complete 64 packets from slot 1 of packet 0, then wrap to 0
        b_bw = n_bw; b_pd = n_pd;
        for (int i = 1; i < int'(NPACK * (WPP + SKIP)); i++) begin
            do_strobe(DW'(i));
            if (i == int'(NPACK * (WPP + SKIP)) - 6) check("bankwrap_early", 32'(n_bw - b_bw), 32'd0);
        end
        check("bank_last_addr", 32'(last_addr), 32'd2046);
        check("bank_wrap", 32'(n_bw - b_bw), 32'd1);
        check("bank_packets", 32'(n_pd - b_pd), 32'd64);
        do_strobe(8'h5A);
        check("bank_restart_addr", 32'(last_addr), 32'd0);

        // SW toggle after 5 slots of packet 3
        for (int i = 1; i < int'(3 * (WPP + SKIP) + 5); i++) do_strobe(DW'(i));
        check("pkt3_slot4_addr", 32'(last_addr), 32'd104);
        b_sw = n_sw;
        @(posedge clk); #1 SW = ~SW;
        model_restart();
        repeat (6) @(posedge clk);
        check("sw_pulse", 32'(n_sw - b_sw), 32'd1);
        do_strobe(8'h77);
        check("sw_next_addr", 32'(last_addr), 32'd0);

        // SW toggle during WESET: latched write completes, next slot at 0
        do_strobe(8'h10);
        model_slot(8'h12, hi);
        @(posedge clk); #1;
        iData = 8'h12;
        strob = 1'b1;
        repeat (10) @(posedge clk);
        #1 SW = ~SW;
        model_restart();
        repeat (25) @(posedge clk);
        #1 strob = 1'b0;
        repeat (5) @(posedge clk);
        check("inflight_addr", 32'(last_addr), 32'd4);
        do_strobe(8'h34);
        check("after_inflight_addr", 32'(last_addr), 32'd0);

        // SW edge coincident with strobe capture: clear wins, slot then written at 0
        do_strobe(8'h55);
        b_sw = n_sw;
        model_restart();
        model_slot(8'h66, hi);
        @(posedge clk); #1;
        iData = 8'h66;
        strob = 1'b1;
        SW = ~SW;
        repeat (hi) @(posedge clk);
        #1 strob = 1'b0;
        repeat (5) @(posedge clk);
        check("coincide_addr", 32'(last_addr), 32'd0);
        check("coincide_swpulse", 32'(n_sw - b_sw), 32'd1);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
